keccak_arbiter: RTL and testbench
=================================

# keccak_arbiter

Shares the single `keccak_top` Keccak-f[1600] permutation core among up to `N_REQ` ML-KEM requesters, such as the hash_G, sampleA and sampleCBD_2k front-ends.
- Grants the core to one requester at a time and latches that requester's padded 1600-bit state.
- Issues the one-cycle start pulse to the core, then detects core completion on the rising edge of its ready signal.
- Returns the permuted state with a one-cycle `done_o` pulse to the winner.
- Sits between the keygen/encap/decap sequencers' modules and the core instance.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `W`, default 1600: Keccak state width in bits. Only 1600 is supported.
- `clk_i` input, 1 bit: clock.
- `rst_i` input, 1 bit: reset, synchronous, active-high.
- `req_i` input, `N_REQ` bits: level request per requester. Must be held until that requester's `done_o` bit pulses.
- `din_i` input, `N_REQ`×`W` bits: per-requester input state in `keccak_1600_t` lane order. Must be valid while `req_i` is high.
- `grant_o` output, `N_REQ` bits: one-hot owner of the core; all zero in `IDLE`.
- `busy_o` output, 1 bit: high in `START`, `BUSY` and `RESP`.
- `done_o` output, `N_REQ` bits: one-cycle completion pulse to the owner.
- `dout_o` output, `W` bits: permuted state. Valid in the `done_o` cycle and held until the next completion.
- `core_start_o` output, 1 bit: one-cycle pulse; drives the core `Reset` input.
- `core_din_o` output, `W` bits: registered state driven to the core `InData` input.
- `core_rdy_i` input, 1 bit: the core `Ready` output.
- `core_dout_i` input, `W` bits: the core `OutData` output.

## Operation
- The FSM has four states: `IDLE`, `START`, `BUSY`, `RESP`.
- `IDLE`
  - If any `req_i` bit is set, pick winner `w`.
  - At the clock edge: `gnt_idx<=w`, `core_din_o<=din_i[w]`, `grant_o<=onehot(w)`, then go to `START`.
  - Otherwise stay in `IDLE`.
- `START`
  - `core_start_o=1` for exactly this cycle, then go to `BUSY`.
- `BUSY`
  - Wait for a rising edge of `core_rdy_i`, i.e. `core_rdy_i & ~rdy_q`, where `rdy_q` is `core_rdy_i` registered every cycle.
  - A `core_rdy_i` level that is already high when `BUSY` is entered is ignored; a low-to-high transition is required.
  - On the edge: `dout_o<=core_dout_i`, then go to `RESP`.
- `RESP`
  - `done_o[gnt_idx]=1` for one cycle.
  - Round-robin pointer `ptr<=(gnt_idx+1) mod N_REQ`.
  - Go to `IDLE`; `grant_o` clears on entering `IDLE`.
- Arbitration is round-robin: `w` is the first set `req_i` bit scanning upward from `ptr` and wrapping modulo `N_REQ`.
- `din_i` is sampled only at the grant edge. The requester may change `din_i` while `BUSY`.
- Request withdrawal:
  - Dropping `req_i` before the grant means the requester is not served.
  - Dropping it after the grant does not abort the job; `done_o` still pulses.
- A requester must drop `req_i` by the edge that ends its `done_o` cycle; otherwise it is re-arbitrated as a new request.
- The arbiter does not inspect or modify state contents. Padding and rate/capacity layout are the requester's responsibility.

## Timing
- Reset values: FSM=`IDLE`, `ptr=0`, `grant_o=0`, `busy_o=0`, `done_o=0`, `core_start_o=0`, `core_din_o=0`, `dout_o=0`, `rdy_q=0`.
- Latency, with `req_i` sampled high in `IDLE` at edge k:
  - `core_start_o` is high in cycle k+1.
  - The core ready rising edge is sampled at edge m > k+1.
  - `done_o` and `dout_o` are valid in cycle m+1.
  - Total latency is core latency + 3 cycles.
- Back-to-back: the minimum spacing between successive `core_start_o` pulses is core latency + 4 cycles, with one `IDLE` cycle between jobs.
- Simultaneous requests: exactly one grant per `IDLE` cycle; the others wait. No requester waits more than `N_REQ-1` jobs.
- Reset mid-operation (`rst_i` in any state): the next cycle is `IDLE` with all outputs at reset values and no `done_o`. The core is not reset; the next `core_start_o` restarts it.
- `core_rdy_i` toggling while in `IDLE`, `START` or `RESP` is ignored, but `rdy_q` still tracks it.

## Configuration
- `KECCAK_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; the lowest set `req_i` index always wins, and `ptr` is not implemented.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Single request: `req_i=4'b0010`, `din_i[1]`=SHA3-512 padded block of the 32-byte all-zero d with k=2; core model ready after 24 cycles. Required: `core_start_o` pulses once; `grant_o=4'b0010`; `done_o=4'b0010` at start+25 cycles; `dout_o` equals golden G output.
- Contention: `req_i=4'b1111` held, each requester dropping its `req_i` after its `done_o`. Required: grant order 0,1,2,3, and exactly four `core_start_o` pulses with identical spacing.
- Fairness: `req_i[0]` permanently high, `req_i[2]` raised mid-job of 0. Required: next grant goes to 2, then back to 0. With `KECCAK_ARB_FIXED_PRIO_EN`, 2 is never granted.
- Stale ready: `core_rdy_i` held high through `START` and the first `BUSY` cycle, falling at +3 and rising at +20. Required: no `done_o` until the cycle after the +20 edge.
- Reset mid-job: assert `rst_i` for one cycle in `BUSY`. Required: next cycle `grant_o=0`, `busy_o=0`, `done_o=0`; a later ready edge produces no `done_o`; the next request is served normally.
- Withdrawal: `req_i[3]` pulsed for 1 cycle while the arbiter is busy with 0. Required: requester 3 is never granted.

Source files
------------

// File: rtl/keccak_arbiter_if.sv
// keccak_arbiter_if: requester-side and core-side signals of the shared Keccak-f[1600] arbiter
interface keccak_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W = 1600
);
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0][W-1:0] din_i;
  logic [N_REQ-1:0] grant_o;
  logic busy_o;
  logic [N_REQ-1:0] done_o;
  logic [W-1:0] dout_o;
  logic core_start_o;
  logic [W-1:0] core_din_o;
  logic core_rdy_i;
  logic [W-1:0] core_dout_i;
  modport slave (
    input req_i, din_i, core_rdy_i, core_dout_i,
    output grant_o, busy_o, done_o, dout_o, core_start_o, core_din_o
  );
  modport master (
    output req_i, din_i, core_rdy_i, core_dout_i,
    input grant_o, busy_o, done_o, dout_o, core_start_o, core_din_o
  );
endinterface

// File: rtl/keccak_arbiter.sv
// keccak_arbiter: shares one keccak_top core among N_REQ requesters (round-robin by default).
// Define KECCAK_ARB_FIXED_PRIO_EN for fixed priority (lowest set req_i index wins, no pointer).
module keccak_arbiter #(
  parameter int N_REQ = 4,
  parameter int W = 1600
) (
  input logic clk_i,
  input logic rst_i,
  keccak_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [IW-1:0] gnt_idx, win;
  logic rdy_q;
  logic any_req, rdy_edge;
  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction
`ifdef KECCAK_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (bus.req_i[i]) win = IW'(i);
  end
`else
  logic [IW-1:0] ptr;
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int i);
    logic [IW:0] s;
    s = {1'b0, p} + (IW+1)'(i);
    return (s >= (IW+1)'(N_REQ)) ? IW'(s - (IW+1)'(N_REQ)) : IW'(s);
  endfunction
  // Scan downward so the last hit is the first set request at or after ptr.
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (bus.req_i[rr_idx(ptr, i)]) win = rr_idx(ptr, i);
  end
`endif
  assign any_req = |bus.req_i;
  assign rdy_edge = bus.core_rdy_i & ~rdy_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (any_req) state_n = START;
      START: state_n = BUSY;
      BUSY: if (rdy_edge) state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  assign bus.busy_o = state != IDLE;
  assign bus.core_start_o = state == START;
  assign bus.done_o = (state == RESP) ? onehot(gnt_idx) : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt_idx <= '0;
      bus.grant_o <= '0;
      bus.core_din_o <= '0;
      bus.dout_o <= '0;
      rdy_q <= 1'b0;
`ifndef KECCAK_ARB_FIXED_PRIO_EN
      ptr <= '0;
`endif
    end else begin
      state <= state_n;
      rdy_q <= bus.core_rdy_i;
      if (state == IDLE && any_req) begin
        gnt_idx <= win;
        bus.grant_o <= onehot(win);
        bus.core_din_o <= bus.din_i[win];
      end
      if (state == BUSY && rdy_edge) bus.dout_o <= bus.core_dout_i;
      if (state == RESP) begin
        bus.grant_o <= '0;
`ifndef KECCAK_ARB_FIXED_PRIO_EN
        ptr <= rr_idx(gnt_idx, 1);
`endif
      end
    end
  end
endmodule

// File: tb/tb_keccak_arbiter.sv
// tb_keccak_arbiter: directed vectors plus multi-cycle sequences against a behavioural core model
module tb_keccak_arbiter;
  localparam int N = 4;
  localparam int W = 1600;
  localparam int LAT = 23;
  localparam logic [W-1:0] MASK = {25{64'hA5C3_0F96_5A3C_F069}};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  keccak_arbiter_if #(.N_REQ(N), .W(W)) bus();
  keccak_arbiter #(.N_REQ(N), .W(W)) dut(.clk_i(clk), .rst_i(rst), .bus(bus));
  int n_cmp = 0;
  int n_fail = 0;
  logic mdl_rdy = 1'b1;
  int cnt = 0;
  logic [W-1:0] mdl_out = '0;
  logic manual = 1'b0;
  logic man_rdy = 1'b0;
  logic [N-1:0][W-1:0] din;
  // Core model: ready drops on start, rises LAT edges later; output is input xor MASK
  always @(posedge clk) begin
    if (bus.core_start_o) begin
      mdl_rdy <= 1'b0;
      cnt <= LAT;
      mdl_out <= bus.core_din_o ^ MASK;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) mdl_rdy <= 1'b1;
    end
  end
  assign bus.core_rdy_i = manual ? man_rdy : mdl_rdy;
  assign bus.core_dout_i = mdl_out;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic check_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got low word %h want low word %h", nm, act[63:0], exp[63:0]);
    end
  endtask
  function automatic int oh2i(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_i = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic run_job(input logic [N-1:0] r, input int w, input string nm);
    int s = -1;
    int starts = 0;
    logic got = 1'b0;
    @(negedge clk);
    bus.req_i = r;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (bus.core_start_o) begin
        starts++;
        s = t;
        check({nm, " grant"}, 64'(bus.grant_o), 64'(1) << w);
      end
      if (bus.done_o != '0) begin
        got = 1'b1;
        check({nm, " done"}, 64'(bus.done_o), 64'(1) << w);
        check({nm, " latency"}, 64'(t - s), 64'(LAT + 2));
        check({nm, " starts"}, 64'(starts), 64'd1);
        check_w({nm, " dout"}, bus.dout_o, din[w] ^ MASK);
        bus.req_i = '0;
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: got no done want done", nm);
    end
    @(negedge clk);
    check({nm, " idle grant"}, 64'(bus.grant_o), 64'd0);
    check({nm, " idle busy"}, 64'(bus.busy_o), 64'd0);
  endtask
  typedef struct {
    logic [N-1:0] req;
    int rr;
    int fp;
  } vec_t;
  vec_t vt[6];
  initial begin
    int gr[3];
    int st[4];
    int ord[4];
    int ng, nd, s0, cnt3, cntd;
    logic got;
    vt[0] = '{4'b0010, 1, 1};
    vt[1] = '{4'b0011, 0, 0};
    vt[2] = '{4'b1000, 3, 3};
    vt[3] = '{4'b0110, 1, 1};
    vt[4] = '{4'b0101, 2, 0};
    vt[5] = '{4'b1001, 3, 0};
    for (int i = 0; i < N; i++) din[i] = {25{64'(i + 1) * 64'h1111_2222_3333_4445}};
    din[1] = '0;
    din[1][257] = 1'b1;
    din[1][265] = 1'b1;
    din[1][266] = 1'b1;
    din[1][575] = 1'b1;
    bus.din_i = din;
    bus.req_i = '0;
    repeat (2) @(negedge clk);
    check("rst grant", 64'(bus.grant_o), 64'd0);
    check("rst busy", 64'(bus.busy_o), 64'd0);
    check("rst done", 64'(bus.done_o), 64'd0);
    check("rst start", 64'(bus.core_start_o), 64'd0);
    check_w("rst core_din", bus.core_din_o, '0);
    check_w("rst dout", bus.dout_o, '0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
`ifdef KECCAK_ARB_FIXED_PRIO_EN
      run_job(vt[i].req, vt[i].fp, $sformatf("vec%0d", i));
`else
      run_job(vt[i].req, vt[i].rr, $sformatf("vec%0d", i));
`endif
    // Contention: all four request; each input is scrambled after its grant
    do_reset();
    @(negedge clk);
    bus.req_i = '1;
    ng = 0;
    nd = 0;
    for (int t = 0; t < 400 && nd < 4; t++) begin
      @(negedge clk);
      if (bus.core_start_o && ng < 4) begin
        st[ng] = t;
        ord[ng] = oh2i(bus.grant_o);
        if (ord[ng] >= 0) bus.din_i[ord[ng]] = ~din[ord[ng]];
        ng++;
      end
      if (bus.done_o != '0) begin
        check_w($sformatf("cont dout%0d", nd), bus.dout_o, din[oh2i(bus.done_o)] ^ MASK);
        bus.req_i = bus.req_i & ~bus.done_o;
        nd++;
      end
    end
    check("cont starts", 64'(ng), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("cont order%0d", i), 64'(ord[i]), 64'(i));
    for (int i = 1; i < 4; i++) check($sformatf("cont spacing%0d", i), 64'(st[i] - st[i-1]), 64'(LAT + 4));
    bus.din_i = din;
    // Fairness: 0 held forever, 2 raised mid-job of 0
    do_reset();
    @(negedge clk);
    bus.req_i = 4'b0001;
    ng = 0;
    s0 = 0;
    for (int t = 0; t < 300 && ng < 3; t++) begin
      @(negedge clk);
      if (bus.core_start_o) begin
        gr[ng] = oh2i(bus.grant_o);
        if (ng == 0) s0 = t;
        ng++;
      end
      if (ng == 1 && t == s0 + 5) bus.req_i[2] = 1'b1;
      if (bus.done_o[2]) bus.req_i[2] = 1'b0;
    end
    bus.req_i = '0;
`ifdef KECCAK_ARB_FIXED_PRIO_EN
    check("fair g0", 64'(gr[0]), 64'd0);
    check("fair g1", 64'(gr[1]), 64'd0);
    check("fair g2", 64'(gr[2]), 64'd0);
`else
    check("fair g0", 64'(gr[0]), 64'd0);
    check("fair g1", 64'(gr[1]), 64'd2);
    check("fair g2", 64'(gr[2]), 64'd0);
`endif
    for (int t = 0; t < 100 && bus.busy_o; t++) @(negedge clk);
    check("fair idle", 64'(bus.busy_o), 64'd0);
    // Stale ready: high through START and the first BUSY cycle
    do_reset();
    manual = 1'b1;
    man_rdy = 1'b1;
    @(negedge clk);
    bus.req_i = 4'b0001;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      got = bus.core_start_o;
    end
    check("stale start", 64'(got), 64'd1);
    bus.req_i = '0;
    for (int j = 0; j <= 24; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("stale done j%0d", j), 64'(bus.done_o), (j == 20) ? 64'd1 : 64'd0);
      if (j == 20) check_w("stale dout", bus.dout_o, din[0] ^ MASK);
      if (j == 2) man_rdy = 1'b0;
      if (j == 19) man_rdy = 1'b1;
    end
    manual = 1'b0;
    // Reset in BUSY: the later ready edge must not complete anything
    do_reset();
    @(negedge clk);
    bus.req_i = 4'b0001;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      got = bus.core_start_o;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.req_i = '0;
    @(negedge clk);
    rst = 1'b0;
    check("mrst grant", 64'(bus.grant_o), 64'd0);
    check("mrst busy", 64'(bus.busy_o), 64'd0);
    check("mrst done", 64'(bus.done_o), 64'd0);
    cntd = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bus.done_o != '0) cntd++;
    end
    check("mrst late done", 64'(cntd), 64'd0);
    run_job(4'b0100, 2, "mrst next");
    // Withdrawal: requester 3 pulses for one cycle while 0 is being served
    do_reset();
    @(negedge clk);
    bus.req_i = 4'b0001;
    cnt3 = 0;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (bus.grant_o[3]) cnt3++;
      if (t == 4) bus.req_i[3] = 1'b1;
      if (t == 5) bus.req_i[3] = 1'b0;
      if (bus.done_o[0]) begin
        got = 1'b1;
        bus.req_i = '0;
      end
    end
    check("wd done0", 64'(got), 64'd1);
    cntd = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.grant_o[3]) cnt3++;
      if (bus.core_start_o) cntd++;
    end
    check("wd grant3", 64'(cnt3), 64'd0);
    check("wd starts", 64'(cntd), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
